exe_pipe_reg_chain: RTL

- Parametrised successor to the single-stage EXE/MEM pipeline register in the ARM core.
- Carries EXE results (control enables, ALU result, Rm value, destination register) through DEPTH register stages toward MEM.
- Adds per-stage valid tracking, freeze (stall), and flush (branch kill).
- Adds an occupancy count and a hazard-detection port that compares decode-stage source registers against every in-flight destination.

---
 rtl/exe_pipe_reg_chain.sv | 119 +++++++++++
 1 files changed

// File: rtl/exe_pipe_reg_chain.sv
// exe_pipe_reg_chain: DEPTH-stage EXE->MEM pipeline register with per-stage
// valid tracking, freeze/flush control, occupancy count and RAW hazard detect.
module exe_pipe_reg_chain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 4,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_freeze,
  input  logic              i_flush,
  input  logic              i_valid_in,
  input  logic              i_wb_en_in,
  input  logic              i_mem_r_en_in,
  input  logic              i_mem_w_en_in,
  input  logic [DATA_W-1:0] i_alu_res_in,
  input  logic [DATA_W-1:0] i_val_rm_in,
  input  logic [DEST_W-1:0] i_dest_in,
  input  logic [DEST_W-1:0] i_src1,
  input  logic [DEST_W-1:0] i_src2,
  input  logic              i_two_src,
  output logic              o_valid,
  output logic              o_wb_en,
  output logic              o_mem_r_en,
  output logic              o_mem_w_en,
  output logic [DATA_W-1:0] o_alu_res,
  output logic [DATA_W-1:0] o_val_rm,
  output logic [DEST_W-1:0] o_dest,
  output logic [CNT_W-1:0]  o_occupancy,
  output logic              o_hazard
);

  // Reject unsupported chain lengths at elaboration.
  generate
    if (DEPTH == 0 || DEPTH > 4) begin : g_bad_depth
      $error("exe_pipe_reg_chain: DEPTH must be in 1..4");
    end
  endgenerate

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_wb_en;
  logic [DEPTH-1:0]  r_mem_r_en;
  logic [DEPTH-1:0]  r_mem_w_en;
  logic [DATA_W-1:0] r_alu_res [DEPTH];
  logic [DATA_W-1:0] r_val_rm  [DEPTH];
  logic [DEST_W-1:0] r_dest    [DEPTH];

  logic [CNT_W-1:0]  w_occupancy;
  logic              w_hazard;

  // Stage registers: flush kills control bits only, freeze holds everything,
  // otherwise stage 0 captures (enables gated by valid) and the rest shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_wb_en    <= '0;
      r_mem_r_en <= '0;
      r_mem_w_en <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_alu_res[i] <= '0;
        r_val_rm[i]  <= '0;
        r_dest[i]    <= '0;
      end
    end else if (i_flush) begin
      r_valid    <= '0;
      r_wb_en    <= '0;
      r_mem_r_en <= '0;
      r_mem_w_en <= '0;
    end else if (!i_freeze) begin
      r_valid[0]    <= i_valid_in;
      r_wb_en[0]    <= i_wb_en_in & i_valid_in;
      r_mem_r_en[0] <= i_mem_r_en_in & i_valid_in;
      r_mem_w_en[0] <= i_mem_w_en_in & i_valid_in;
      r_alu_res[0]  <= i_alu_res_in;
      r_val_rm[0]   <= i_val_rm_in;
      r_dest[0]     <= i_dest_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i]    <= r_valid[i-1];
        r_wb_en[i]    <= r_wb_en[i-1];
        r_mem_r_en[i] <= r_mem_r_en[i-1];
        r_mem_w_en[i] <= r_mem_w_en[i-1];
        r_alu_res[i]  <= r_alu_res[i-1];
        r_val_rm[i]   <= r_val_rm[i-1];
        r_dest[i]     <= r_dest[i-1];
      end
    end
  end

  // Occupancy: popcount of stage valid bits.
  always_comb begin
    w_occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occupancy = w_occupancy + CNT_W'(r_valid[i]);
    end
  end

  // RAW hazard: any valid, writing stage whose dest matches a live source.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && r_wb_en[i] &&
          ((r_dest[i] == i_src1) || (i_two_src && (r_dest[i] == i_src2)))) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign o_valid     = r_valid[DEPTH-1];
  assign o_wb_en     = r_wb_en[DEPTH-1];
  assign o_mem_r_en  = r_mem_r_en[DEPTH-1];
  assign o_mem_w_en  = r_mem_w_en[DEPTH-1];
  assign o_alu_res   = r_alu_res[DEPTH-1];
  assign o_val_rm    = r_val_rm[DEPTH-1];
  assign o_dest      = r_dest[DEPTH-1];
  assign o_occupancy = w_occupancy;
  assign o_hazard    = w_hazard;

endmodule
